// File: rtl/mac_pkg.sv
// Shared types, constants and saturation helpers for the 4-lane Q2.14 MAC sequencer.
package mac_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH;
    localparam int unsigned FRAC_BITS  = 14;
    localparam int unsigned LANES      = 4;

    localparam logic signed [DATA_WIDTH-1:0] Q14_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] Q14_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Q2.14 limits sign-extended to accumulator width for comparison.
    localparam logic signed [ACC_WIDTH-1:0] Q14_MAX_EXT = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, Q14_MAX};
    localparam logic signed [ACC_WIDTH-1:0] Q14_MIN_EXT = {{(ACC_WIDTH-DATA_WIDTH){1'b1}}, Q14_MIN};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

    // One extra guard bit is enough: the sum of two ACC values overflows by at most one bit.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] sum);
        logic signed [ACC_WIDTH-1:0] res;
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            res = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            res = sum[ACC_WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_q14(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [DATA_WIDTH-1:0] res;
        if (acc > Q14_MAX_EXT) begin
            res = Q14_MAX;
        end else if (acc < Q14_MIN_EXT) begin
            res = Q14_MIN;
        end else begin
            res = acc[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mac4_dot_sequencer_lane_mask.sv
// Lane enables for one buffer word: lane i is live when its global element index is below len.
module lane_mask
    import mac_pkg::*;
#(
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic [ADDR_WIDTH-1:0] i_word_idx,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic [LANES-1:0]      o_lane_en_c
);

    localparam int unsigned IDX_W =
        (((ADDR_WIDTH + 2) > LEN_WIDTH) ? (ADDR_WIDTH + 2) : LEN_WIDTH) + 1;

    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_len;

    assign w_base = IDX_W'(i_word_idx) * IDX_W'(LANES);
    assign w_len  = IDX_W'(i_len);

    always_comb begin
        o_lane_en_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            o_lane_en_c[i] = (w_base + IDX_W'(i)) < w_len;
        end
    end

endmodule

// File: rtl/mac4_dot_sequencer.sv
// Initiator for an external mac4: streams packed Q2.14 vector words, accumulates partial sums,
// and returns one saturated dot product per job. Optional bias input under MAC4_SEQ_BIAS_EN.
module mac4_dot_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
`ifdef MAC4_SEQ_BIAS_EN
    input  logic [DATA_WIDTH-1:0]       bias,
`endif
    output logic                        busy,
    output logic                        rd_en,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [LANES*DATA_WIDTH-1:0] rd_data_a,
    input  logic [LANES*DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0]       mac_a0,
    output logic [DATA_WIDTH-1:0]       mac_a1,
    output logic [DATA_WIDTH-1:0]       mac_a2,
    output logic [DATA_WIDTH-1:0]       mac_a3,
    output logic [DATA_WIDTH-1:0]       mac_b0,
    output logic [DATA_WIDTH-1:0]       mac_b1,
    output logic [DATA_WIDTH-1:0]       mac_b2,
    output logic [DATA_WIDTH-1:0]       mac_b3,
    input  logic [ACC_WIDTH-1:0]        mac_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [ACC_WIDTH-1:0]        out_acc
);

    seq_state_e r_state;
    seq_state_e w_state_nxt;

    logic [LEN_WIDTH-1:0]         r_len;
    logic [ADDR_WIDTH-1:0]        r_last_addr;
    logic                         r_busy;
    logic                         r_rd_en;
    logic [ADDR_WIDTH-1:0]        r_rd_addr;
    logic                         r_data_vld;
    logic [ADDR_WIDTH-1:0]        r_data_idx;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic signed [ACC_WIDTH-1:0]  r_out_acc;

    logic                         w_accept;
    logic                         w_fetch_last;
    logic                         w_load_out;
    logic                         w_handshake;
    logic [LEN_WIDTH:0]           w_words;
    logic [ADDR_WIDTH-1:0]        w_last_addr;
    logic signed [ACC_WIDTH-1:0]  w_acc_init;
    logic signed [ACC_WIDTH:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic [LANES-1:0]             w_lane_en;
    logic [DATA_WIDTH-1:0]        w_op_a [LANES];
    logic [DATA_WIDTH-1:0]        w_op_b [LANES];

    // Word count is ceil(len/4); one guard bit keeps len+3 from wrapping.
    assign w_words     = ({1'b0, len} + (LEN_WIDTH+1)'(3)) >> 2;
    assign w_last_addr = ADDR_WIDTH'(w_words - (LEN_WIDTH+1)'(1));

`ifdef MAC4_SEQ_BIAS_EN
    assign w_acc_init = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
`else
    assign w_acc_init = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (len != '0) ? FETCH : OUT;
            FETCH:   if (r_rd_addr == r_last_addr) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = OUT;
            OUT:     if (r_out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output loads on the DRAIN edge, or one cycle into OUT for an empty job.
    always_comb begin
        w_accept     = 1'b0;
        w_fetch_last = 1'b0;
        w_load_out   = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE:  w_accept     = start;
            FETCH: w_fetch_last = (r_rd_addr == r_last_addr);
            DRAIN: w_load_out   = 1'b1;
            OUT: begin
                w_load_out  = !r_out_valid;
                w_handshake = r_out_valid && out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_last_addr <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len       <= len;
                r_last_addr <= w_last_addr;
                r_rd_en     <= (len != '0);
                r_rd_addr   <= '0;
                r_busy      <= 1'b1;
            end else if (r_state == FETCH) begin
                if (w_fetch_last) begin
                    r_rd_en <= 1'b0;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                end
            end
            if (w_handshake) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Read data returns one cycle after the strobe; track which word it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_vld <= 1'b0;
            r_data_idx <= '0;
        end else begin
            r_data_vld <= r_rd_en;
            r_data_idx <= r_rd_addr;
        end
    end

    lane_mask #(
        .LEN_WIDTH  (LEN_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane_mask (
        .i_word_idx  (r_data_idx),
        .i_len       (r_len),
        .o_lane_en_c (w_lane_en)
    );

    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            w_op_a[i] = '0;
            w_op_b[i] = '0;
            if (r_data_vld && w_lane_en[i]) begin
                w_op_a[i] = rd_data_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_op_b[i] = rd_data_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mac_a0 = w_op_a[0];
    assign mac_a1 = w_op_a[1];
    assign mac_a2 = w_op_a[2];
    assign mac_a3 = w_op_a[3];
    assign mac_b0 = w_op_b[0];
    assign mac_b1 = w_op_b[1];
    assign mac_b2 = w_op_b[2];
    assign mac_b3 = w_op_b[3];

    always_comb begin
        w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + {mac_result[ACC_WIDTH-1], mac_result};
        w_acc_next = r_data_vld ? sat_acc(w_sum) : r_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_init;
        end else if (r_data_vld) begin
            r_acc <= w_acc_next;
        end
    end

    // Result registers are frozen while waiting for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_acc   <= '0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_out_data  <= sat_q14(w_acc_next);
            r_out_acc   <= w_acc_next;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    assign busy      = r_busy;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_acc   = r_out_acc;

endmodule
